// File: rtl/axi_gpu_mem_slave.sv
// AXI4 burst memory slave (FIXED/INCR/WRAP, strobes, SLVERR); GPU_MEM_PERF_EN adds beat/error counters.
// Latency: RVALID one cycle after AR, B after last W beat; one beat/cycle per channel, R data held while !RREADY.
module axi_gpu_mem_slave #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 64,
    parameter int                ID_W      = 4,
    parameter int                MEM_BYTES = 8192,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [ID_W-1:0]     S_AWID,
    input  logic [ADDR_W-1:0]   S_AWADDR,
    input  logic [7:0]          S_AWLEN,
    input  logic [2:0]          S_AWSIZE,
    input  logic [1:0]          S_AWBURST,
    input  logic                S_AWVALID,
    output logic                S_AWREADY,
    input  logic [DATA_W-1:0]   S_WDATA,
    input  logic [DATA_W/8-1:0] S_WSTRB,
    input  logic                S_WLAST,
    input  logic                S_WVALID,
    output logic                S_WREADY,
    output logic [ID_W-1:0]     S_BID,
    output logic [1:0]          S_BRESP,
    output logic                S_BVALID,
    input  logic                S_BREADY,
    input  logic [ID_W-1:0]     S_ARID,
    input  logic [ADDR_W-1:0]   S_ARADDR,
    input  logic [7:0]          S_ARLEN,
    input  logic [2:0]          S_ARSIZE,
    input  logic [1:0]          S_ARBURST,
    input  logic                S_ARVALID,
    output logic                S_ARREADY,
    output logic [ID_W-1:0]     S_RID,
    output logic [DATA_W-1:0]   S_RDATA,
    output logic [1:0]          S_RRESP,
    output logic                S_RLAST,
    output logic                S_RVALID,
    input  logic                S_RREADY
`ifdef GPU_MEM_PERF_EN
    ,
    output logic [31:0]         perf_wr_beats,
    output logic [31:0]         perf_rd_beats,
    output logic [15:0]         perf_err_cnt
`endif
);
    localparam int B     = DATA_W / 8;
    localparam int BL    = $clog2(B);
    localparam int ML    = $clog2(MEM_BYTES);
    localparam int WORDS = MEM_BYTES / B;
    localparam int IW    = ML - BL;

    localparam logic [1:0] WRAP   = 2'b10;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic [DATA_W-1:0] mem [WORDS];

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [7:0] len, input logic [1:0] burst);
        logic [ADDR_W-1:0] mask;
        logic [ADDR_W-1:0] inc;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << BL) - ADDR_W'(1);
        inc  = a + ADDR_W'(B);
        case (burst)
            INCR:    return inc;
            WRAP:    return (a & ~mask) | (inc & mask);
            default: return a;
        endcase
    endfunction

    function automatic logic bad_burst(input logic [2:0] size, input logic [7:0] len, input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size != 3'(BL)) || (burst == 2'b11) || (burst == WRAP && !wrap_len_ok);
    endfunction

    // Extra top bit catches addr < BASE_ADDR as a borrow; any bit at or above ML is out of window.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] d;
        d = {1'b0, a} - {1'b0, BASE_ADDR};
        return |(d >> ML);
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] d;
        d = a - BASE_ADDR;
        return IW'(d >> BL);
    endfunction

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    w_state_t          w_state, w_state_nxt;
    logic [ID_W-1:0]   w_id;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len, w_cnt;
    logic [1:0]        w_burst;
    logic              w_bad, w_err;
    logic              w_beat, w_last_beat, w_beat_err;

    assign w_beat      = S_WVALID && S_WREADY;
    assign w_last_beat = (w_cnt == w_len);
    assign w_beat_err  = w_bad || addr_bad(w_addr);
    assign S_BID       = w_id;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) w_state <= W_IDLE;
        else        w_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (S_AWVALID) w_state_nxt = W_DATA;
            W_DATA:  if (S_WVALID && w_last_beat) w_state_nxt = W_RESP;
            W_RESP:  if (S_BREADY) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        S_AWREADY = 1'b0;
        S_WREADY  = 1'b0;
        S_BVALID  = 1'b0;
        S_BRESP   = OKAY;
        if (!ARESET) begin
            case (w_state)
                W_IDLE:  S_AWREADY = 1'b1;
                W_DATA:  S_WREADY  = 1'b1;
                W_RESP: begin
                    S_BVALID = 1'b1;
                    S_BRESP  = w_err ? SLVERR : OKAY;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_bad   <= 1'b0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (S_AWVALID && S_AWREADY) begin
            w_id    <= S_AWID;
            w_addr  <= S_AWADDR;
            w_len   <= S_AWLEN;
            w_burst <= S_AWBURST;
            w_bad   <= bad_burst(S_AWSIZE, S_AWLEN, S_AWBURST);
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (w_beat) begin
            w_addr <= next_addr(w_addr, w_len, w_burst);
            w_cnt  <= w_cnt + 8'd1;
            w_err  <= w_err || w_beat_err || (S_WLAST != w_last_beat);
        end
    end

    // Memory contents survive reset so a burst cut short by reset leaves its beats in place.
    always_ff @(posedge ACLK) begin
        if (w_beat && !w_beat_err) begin
            for (int i = 0; i < B; i++) begin
                if (S_WSTRB[i]) mem[word_idx(w_addr)][8*i +: 8] <= S_WDATA[8*i +: 8];
            end
        end
    end

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    r_state_t          r_state, r_state_nxt;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len, r_cnt;
    logic [1:0]        r_burst;
    logic              r_bad;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_last;
    logic              ar_hs, r_hs, ld_en, ld_bad, ld_err;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_len;
    logic [1:0]        ld_burst;

    // r_addr always holds the address of the beat after the one currently presented.
    assign ar_hs    = S_ARVALID && S_ARREADY;
    assign r_hs     = S_RVALID && S_RREADY;
    assign ld_en    = ar_hs || (r_hs && !r_last);
    assign ld_addr  = ar_hs ? S_ARADDR : r_addr;
    assign ld_len   = ar_hs ? S_ARLEN : r_len;
    assign ld_burst = ar_hs ? S_ARBURST : r_burst;
    assign ld_bad   = ar_hs ? bad_burst(S_ARSIZE, S_ARLEN, S_ARBURST) : r_bad;
    assign ld_err   = ld_bad || addr_bad(ld_addr);

    assign S_RID   = r_id;
    assign S_RDATA = r_data;
    assign S_RRESP = r_resp;
    assign S_RLAST = r_last;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_state <= R_IDLE;
        else        r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (S_ARVALID) r_state_nxt = R_DATA;
            R_DATA:  if (S_RREADY && r_last) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        S_ARREADY = 1'b0;
        S_RVALID  = 1'b0;
        if (!ARESET) begin
            S_ARREADY = (r_state == R_IDLE);
            S_RVALID  = (r_state == R_DATA);
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_id    <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_bad   <= 1'b0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_resp  <= OKAY;
            r_last  <= 1'b0;
        end else begin
            if (ar_hs) begin
                r_id    <= S_ARID;
                r_len   <= S_ARLEN;
                r_burst <= S_ARBURST;
                r_bad   <= ld_bad;
            end
            if (ld_en) begin
                r_data <= ld_err ? '0 : mem[word_idx(ld_addr)];
                r_resp <= ld_err ? SLVERR : OKAY;
                r_last <= ar_hs ? (S_ARLEN == 8'd0) : (r_cnt + 8'd1 == r_len);
                r_addr <= next_addr(ld_addr, ld_len, ld_burst);
                r_cnt  <= ar_hs ? 8'd0 : r_cnt + 8'd1;
            end
        end
    end

`ifdef GPU_MEM_PERF_EN
    logic        r_err_seen;
    logic [1:0]  err_inc;
    logic [16:0] err_sum;

    assign err_inc = 2'(S_BVALID && S_BREADY && w_err)
                   + 2'(r_hs && r_last && (r_err_seen || r_resp == SLVERR));
    assign err_sum = 17'(perf_err_cnt) + 17'(err_inc);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            perf_wr_beats <= '0;
            perf_rd_beats <= '0;
            perf_err_cnt  <= '0;
            r_err_seen    <= 1'b0;
        end else begin
            if (w_beat && !w_beat_err && perf_wr_beats != '1) perf_wr_beats <= perf_wr_beats + 32'd1;
            if (r_hs && r_resp == OKAY && perf_rd_beats != '1) perf_rd_beats <= perf_rd_beats + 32'd1;
            if (ar_hs)                           r_err_seen <= 1'b0;
            else if (r_hs && r_resp == SLVERR)   r_err_seen <= 1'b1;
            perf_err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end
`endif

endmodule
